// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, held frame with error flags out, valid/ready handshake
interface uart_rx_if #(parameter int DATA_WIDTH = 8);
    logic                  rx;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  parity_err;
    logic                  framing_err;
    logic                  overrun_err;
    logic                  busy;
    modport master (output rx, rx_ready, input rx_data, rx_valid, parity_err, framing_err, overrun_err, busy);
    modport slave  (input rx, rx_ready, output rx_data, rx_valid, parity_err, framing_err, overrun_err, busy);
endinterface

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: mid-bit sampling UART receiver with parity/stop checks and one-entry holding register
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, COMMIT, BREAK} state_t;
    state_t                state, nxt;
    logic                  rx_m, rx_s, rx_prev;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg, data_q;
    logic                  perr, ferr, valid_q, perr_q, ferr_q, ovr_q;
    logic                  fall, tick, counting, data_last, stop_last;
    assign fall      = !rx_s && rx_prev;
    assign tick      = cnt == '0;
    assign counting  = state inside {START, DATA, PARITY, STOP};
    assign data_last = bit_cnt == BW'(DATA_WIDTH - 1);
    assign stop_last = bit_cnt == BW'(STOP_BITS - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            state   <= IDLE;
        end else begin
            rx_m    <= bus.rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
            state   <= nxt;
        end
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = fall ? START : IDLE;
            START:   nxt = !tick ? START : rx_s ? IDLE : DATA;
            DATA:    nxt = (tick && data_last) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
            PARITY:  nxt = tick ? STOP : PARITY;
            STOP:    nxt = (tick && stop_last) ? COMMIT : STOP;
            COMMIT:  nxt = (ferr && !rx_s) ? BREAK : IDLE;
            BREAK:   nxt = rx_s ? IDLE : BREAK;
            default: nxt = IDLE;
        endcase
    end
    // The bit-period counter idles preloaded with half a bit so START lands mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
        end else begin
            cnt       <= (state == IDLE) ? CW'(CLKS_PER_BIT / 2 - 1) : !counting ? cnt : tick ? CW'(CLKS_PER_BIT - 1) : cnt - 1'b1;
            bit_cnt   <= (state == IDLE) ? '0 : (tick && state == DATA) ? (data_last ? '0 : bit_cnt + 1'b1) : (tick && state == STOP) ? bit_cnt + 1'b1 : bit_cnt;
            shift_reg <= (tick && state == DATA) ? {rx_s, shift_reg[DATA_WIDTH-1:1]} : shift_reg;
            perr      <= (state == IDLE) ? 1'b0 : (tick && state == PARITY) ? (rx_s != (^shift_reg ^ 1'(PARITY_ODD))) : perr;
            ferr      <= (state == IDLE) ? 1'b0 : (tick && state == STOP && !rx_s) ? 1'b1 : ferr;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (state == COMMIT) begin
                if (!valid_q || bus.rx_ready) begin
                    data_q  <= shift_reg;
                    perr_q  <= perr;
                    ferr_q  <= ferr;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && bus.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end
    assign bus.rx_data     = data_q;
    assign bus.rx_valid    = valid_q;
    assign bus.parity_err  = perr_q;
    assign bus.framing_err = ferr_q;
    assign bus.overrun_err = ovr_q;
    assign bus.busy        = state != IDLE;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: table-driven frames plus glitch, break, overrun and reset sequences
module tb_uart_rx_deserializer;
    logic clk, rst;
    int   n_tests, n_fail, cyc, t_start;
    int   n_valid, n_vhigh, n_ovr;
    logic prev_valid;
    uart_rx_if #(.DATA_WIDTH(8)) bus ();
    uart_rx_deserializer dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       exp_pe;
    } vec_t;
    vec_t vecs [6];
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(negedge clk) begin
        cyc++;
        if (bus.rx_valid && !prev_valid) n_valid++;
        if (bus.rx_valid) n_vhigh++;
        if (bus.overrun_err) n_ovr++;
        prev_valid = bus.rx_valid;
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask
    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bus.rx = f[i];
            if (i == 0) t_start = cyc;
            repeat (16) @(negedge clk);
        end
    endtask
    task automatic check_frame(input string name, input logic [7:0] d, input logic pe, input logic fe);
        check({name, "_data"}, bus.rx_data, d);
        check({name, "_perr"}, bus.parity_err, pe);
        check({name, "_ferr"}, bus.framing_err, fe);
    endtask
    initial begin
        int sv, sh, so, lat_cyc;
        logic seen;
        vecs[0] = '{8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1};
        vecs[2] = '{8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1};
        vecs[4] = '{8'h01, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b0, 1'b1};
        n_tests = 0; n_fail = 0; cyc = 0; n_valid = 0; n_vhigh = 0; n_ovr = 0; prev_valid = 1'b0;
        rst = 1'b1; bus.rx = 1'b1; bus.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.rx_valid, 0);
        check("rst_data", bus.rx_data, 0);
        check("rst_flags", {bus.parity_err, bus.framing_err, bus.overrun_err}, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        foreach (vecs[i]) begin
            sv = n_valid; sh = n_vhigh; so = n_ovr;
            lat_cyc = -1;
            fork
                send_frame(vecs[i].d, vecs[i].p, 1'b1);
                begin
                    for (int k = 0; k < 200 && n_valid == sv; k++) @(negedge clk);
                    #1 lat_cyc = cyc - t_start;
                end
            join
            repeat (4) @(negedge clk);
            check_range($sformatf("vec%0d_latency", i), lat_cyc, 170, 174);
            check($sformatf("vec%0d_pulses", i), n_valid - sv, 1);
            check($sformatf("vec%0d_width", i), n_vhigh - sh, 1);
            check($sformatf("vec%0d_ovr", i), n_ovr - so, 0);
            check_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].exp_pe, 1'b0);
        end
        // Stop bit low followed by a held-low line: break condition.
        sv = n_valid;
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        check("brk_busy_low", bus.busy, 1);
        check("brk_pulses", n_valid - sv, 1);
        check_frame("brk", 8'h55, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        bus.rx = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = !bus.busy;
        end
        check("brk_busy_release", seen, 1);
        repeat (8) @(negedge clk);
        send_frame(8'h0F, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_frame("after_brk", 8'h0F, 1'b0, 1'b0);
        // Four-cycle low glitch must be rejected at the mid-start check.
        repeat (10) @(negedge clk);
        sv = n_valid;
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx = 1'b1;
        check("glitch_busy_high", bus.busy, 1);
        seen = 1'b0;
        for (int k = 0; k < 7 && !seen; k++) begin
            @(negedge clk);
            seen = !bus.busy;
        end
        check("glitch_busy_drop", seen, 1);
        check("glitch_no_valid", n_valid - sv, 0);
        send_frame(8'h81, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("glitch_next_pulses", n_valid - sv, 1);
        check_frame("glitch_next", 8'h81, 1'b0, 1'b0);
        // Overrun: second frame dropped while the first is still held.
        repeat (10) @(negedge clk);
        bus.rx_ready = 1'b0;
        sv = n_valid; so = n_ovr;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("ovr_pulses", n_ovr - so, 1);
        check("ovr_valid_rises", n_valid - sv, 1);
        check("ovr_valid", bus.rx_valid, 1);
        check("ovr_data", bus.rx_data, 8'h11);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        check("ovr_drain", bus.rx_valid, 0);
        // Reset in the middle of a frame abandons it.
        repeat (10) @(negedge clk);
        sv = n_valid;
        bus.rx = 1'b0;
        repeat (16) @(negedge clk);
        bus.rx = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_busy", bus.busy, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("mrst_data", bus.rx_data, 0);
        check("mrst_valid", bus.rx_valid, 0);
        check("mrst_flags", {bus.parity_err, bus.framing_err, bus.overrun_err}, 0);
        check("mrst_busy", bus.busy, 0);
        repeat (200) @(negedge clk);
        check("mrst_no_output", n_valid - sv, 0);
        check("mrst_idle", bus.busy, 0);
        send_frame(8'h42, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("mrst_next_pulses", n_valid - sv, 1);
        check_frame("mrst_next", 8'h42, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
